// File: rtl/run_mul_acc_pipe.sv
// run_mul_acc_pipe: pipelined signed/unsigned multiply with optional running accumulate.
// Define RUN_MUL_ACC_SATURATE_EN for saturating conversion/accumulation and a sticky sat_flag output.
module run_mul_acc_pipe #(
  parameter int A_W       = 14,
  parameter int B_W       = 15,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0,
  parameter int P_W       = 29,
  parameter int NUM_STAGE = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  input  logic [A_W-1:0] din0,
  input  logic [B_W-1:0] din1,
  input  logic           in_valid,
  input  logic           acc_en,
  output logic [P_W-1:0] dout,
  output logic           out_valid
`ifdef RUN_MUL_ACC_SATURATE_EN
  ,
  output logic           sat_flag
`endif
);
  localparam int MW = A_W + B_W + 2;
  localparam int XW = (MW > P_W ? MW : P_W) + 2;
  localparam int ND = NUM_STAGE - 2;
  localparam bit RS = (A_SIGNED != 0) || (B_SIGNED != 0);
  logic signed [A_W:0] a_r;
  logic signed [B_W:0] b_r;
  logic v_r, e_r, fv, fe;
  logic signed [MW-1:0] prod, fp;
  logic signed [XW-1:0] px;
  logic [P_W-1:0] acc, nxt;
  always_ff @(posedge clk)
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      v_r <= 1'b0;
      e_r <= 1'b0;
    end else if (ce) begin
      a_r <= {A_SIGNED != 0 && din0[A_W-1], din0};
      b_r <= {B_SIGNED != 0 && din1[B_W-1], din1};
      v_r <= in_valid;
      e_r <= acc_en;
    end
  assign prod = MW'(a_r) * MW'(b_r);
  if (ND == 0) begin : g_comb
    assign fp = prod;
    assign fv = v_r;
    assign fe = e_r;
  end else begin : g_pipe
    logic signed [MW-1:0] p_q [ND];
    logic [ND-1:0] v_q, e_q;
    always_ff @(posedge clk)
      if (reset) begin
        for (int i = 0; i < ND; i++) p_q[i] <= '0;
        v_q <= '0;
        e_q <= '0;
      end else if (ce) begin
        p_q[0] <= prod;
        for (int i = 1; i < ND; i++) p_q[i] <= p_q[i-1];
        v_q <= ND'({v_q, v_r});
        e_q <= ND'({e_q, e_r});
      end
    assign fp = p_q[ND-1];
    assign fv = v_q[ND-1];
    assign fe = e_q[ND-1];
  end
  // exact product value, sign-extended so both conversion modes work from one signal
  assign px = {{(XW-MW){fp[MW-1]}}, fp};
`ifdef RUN_MUL_ACC_SATURATE_EN
  localparam logic signed [XW-1:0] ONE = 1;
  localparam logic signed [XW-1:0] HI = RS ? (ONE <<< (P_W-1)) - ONE : (ONE <<< P_W) - ONE;
  localparam logic signed [XW-1:0] LO = RS ? -(ONE <<< (P_W-1)) : '0;
  logic signed [XW-1:0] pc, ax, sum;
  logic p_cl, s_cl;
  always_comb begin
    p_cl = px > HI || px < LO;
    pc = px > HI ? HI : px < LO ? LO : px;
    ax = {{(XW-P_W){RS && acc[P_W-1]}}, acc};
    sum = fe ? ax + pc : pc;
    s_cl = sum > HI || sum < LO;
    nxt = sum > HI ? P_W'(HI) : sum < LO ? P_W'(LO) : P_W'(sum);
  end
  always_ff @(posedge clk)
    if (reset) sat_flag <= 1'b0;
    else if (ce && fv) sat_flag <= (p_cl || s_cl) ? 1'b1 : fe && sat_flag;
`else
  assign nxt = fe ? acc + P_W'(px) : P_W'(px);
`endif
  always_ff @(posedge clk)
    if (reset) begin
      acc <= '0;
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= fv;
      if (fv) acc <= nxt;
    end
  assign dout = acc;
endmodule

// File: tb/tb_run_mul_acc_pipe.sv
// tb_run_mul_acc_pipe: three configurations of run_mul_acc_pipe against an arithmetic scoreboard model.
module tb_run_mul_acc_pipe;
  localparam int AW [3] = '{14, 8, 8};
  localparam int BW [3] = '{15, 8, 8};
  localparam bit AS [3] = '{0, 1, 0};
  localparam bit BS [3] = '{0, 1, 0};
  localparam int PW [3] = '{29, 16, 8};
  localparam int NS [3] = '{4, 3, 2};
  logic clk = 0;
  logic rst, ce, iv, en;
  logic [15:0] a [3];
  logic [15:0] b [3];
  logic [28:0] dout0;
  logic [15:0] dout1;
  logic [7:0] dout2;
  logic ov0, ov1, ov2;
  int n_chk = 0, n_err = 0, cnt = 0;
  longint acc_m [3], cur [3];
  bit sat_m [3], cur_s [3], ovm [3];
  bit ring_v [3][8], ring_s [3][8];
  longint ring_x [3][8];
`ifdef RUN_MUL_ACC_SATURATE_EN
  logic sat0, sat1, sat2;
`endif
  always #5 clk = ~clk;
  run_mul_acc_pipe #(.A_W(14), .B_W(15), .A_SIGNED(0), .B_SIGNED(0), .P_W(29), .NUM_STAGE(4)) u0 (
    .clk(clk), .reset(rst), .ce(ce), .din0(a[0][13:0]), .din1(b[0][14:0]), .in_valid(iv), .acc_en(en),
    .dout(dout0), .out_valid(ov0)
`ifdef RUN_MUL_ACC_SATURATE_EN
    , .sat_flag(sat0)
`endif
  );
  run_mul_acc_pipe #(.A_W(8), .B_W(8), .A_SIGNED(1), .B_SIGNED(1), .P_W(16), .NUM_STAGE(3)) u1 (
    .clk(clk), .reset(rst), .ce(ce), .din0(a[1][7:0]), .din1(b[1][7:0]), .in_valid(iv), .acc_en(en),
    .dout(dout1), .out_valid(ov1)
`ifdef RUN_MUL_ACC_SATURATE_EN
    , .sat_flag(sat1)
`endif
  );
  run_mul_acc_pipe #(.A_W(8), .B_W(8), .A_SIGNED(0), .B_SIGNED(0), .P_W(8), .NUM_STAGE(2)) u2 (
    .clk(clk), .reset(rst), .ce(ce), .din0(a[2][7:0]), .din1(b[2][7:0]), .in_valid(iv), .acc_en(en),
    .dout(dout2), .out_valid(ov2)
`ifdef RUN_MUL_ACC_SATURATE_EN
    , .sat_flag(sat2)
`endif
  );
  function automatic longint ext(longint v, int w, bit s);
    longint m = (longint'(1) << w) - 1;
    v = v & m;
    return (s && v[w-1]) ? v - (m + 1) : v;
  endfunction
  task automatic chk(string tag, longint obs, longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // new accumulator value (P_W bits) and sticky flag after one sample into configuration d
  task automatic model_issue(int d, output longint r, output bit s);
    bit rs = AS[d] || BS[d];
    longint m = (longint'(1) << PW[d]) - 1;
    longint p = ext(longint'(a[d]), AW[d], AS[d]) * ext(longint'(b[d]), BW[d], BS[d]);
`ifdef RUN_MUL_ACC_SATURATE_EN
    longint hi = rs ? (m >> 1) : m;
    longint lo = rs ? -(m >> 1) - 1 : 0;
    bit c = 0;
    if (p > hi) begin p = hi; c = 1; end
    else if (p < lo) begin p = lo; c = 1; end
    r = en ? ext(acc_m[d], PW[d], rs) + p : p;
    if (r > hi) begin r = hi; c = 1; end
    else if (r < lo) begin r = lo; c = 1; end
    sat_m[d] = c ? 1'b1 : (en && sat_m[d]);
`else
    r = en ? acc_m[d] + p : p;
`endif
    r = r & m;
    acc_m[d] = r;
    s = sat_m[d];
  endtask
  task automatic tick();
    longint r;
    bit s;
    int slot;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 8; k++) ring_v[d][k] = 0;
        acc_m[d] = 0; sat_m[d] = 0; cur[d] = 0; cur_s[d] = 0; ovm[d] = 0;
      end
    end else if (ce) begin
      cnt++;
      for (int d = 0; d < 3; d++) begin
        slot = cnt % 8;
        ovm[d] = ring_v[d][slot];
        if (ovm[d]) begin
          cur[d] = ring_x[d][slot];
          cur_s[d] = ring_s[d][slot];
          ring_v[d][slot] = 0;
        end
        if (iv) begin
          model_issue(d, r, s);
          slot = (cnt + NS[d] - 1) % 8;
          ring_v[d][slot] = 1; ring_x[d][slot] = r; ring_s[d][slot] = s;
        end
      end
    end
    @(negedge clk);
    chk("dout0", longint'(dout0), cur[0]);
    chk("dout1", longint'(dout1), cur[1]);
    chk("dout2", longint'(dout2), cur[2]);
    chk("ov0", longint'(ov0), longint'(ovm[0]));
    chk("ov1", longint'(ov1), longint'(ovm[1]));
    chk("ov2", longint'(ov2), longint'(ovm[2]));
`ifdef RUN_MUL_ACC_SATURATE_EN
    chk("sat0", longint'(sat0), longint'(cur_s[0]));
    chk("sat1", longint'(sat1), longint'(cur_s[1]));
    chk("sat2", longint'(sat2), longint'(cur_s[2]));
`endif
  endtask
  initial begin
    rst = 1; ce = 0; iv = 0; en = 0;
    for (int d = 0; d < 3; d++) begin a[d] = 0; b[d] = 0; end
    tick(); tick();
    chk("reset_dout0", longint'(dout0), 0);
    chk("reset_ov0", longint'(ov0), 0);
    rst = 0; ce = 1;
    iv = 1; en = 0;
    a[0] = 16383; b[0] = 32767; a[1] = 16'h80; b[1] = 16'h80; a[2] = 20; b[2] = 20;
    tick();
    iv = 0;
    tick();
`ifdef RUN_MUL_ACC_SATURATE_EN
    chk("sat_clamp", longint'(dout2), 255);
    chk("sat_flag_set", longint'(sat2), 1);
`else
    chk("wrap_trunc", longint'(dout2), 144);
`endif
    tick();
    chk("signed_mul", longint'(dout1), 16384);
    tick();
    chk("full_mul", longint'(dout0), 536821761);
    chk("full_ov", longint'(ov0), 1);
    tick();
    chk("ov_pulse_end", longint'(ov0), 0);
    iv = 1; a[1] = 16'hFF; b[1] = 5; a[2] = 2; b[2] = 3;
    tick();
    iv = 0;
    tick();
    chk("load_after_sat", longint'(dout2), 6);
`ifdef RUN_MUL_ACC_SATURATE_EN
    chk("sat_flag_clear", longint'(sat2), 0);
`endif
    tick();
    chk("signed_neg", longint'(dout1), 16'hFFFB);
    tick(); tick();
    iv = 1; en = 0; a[0] = 3; b[0] = 4;
    tick();
    en = 1; a[0] = 5; b[0] = 6;
    tick();
    a[0] = 2; b[0] = 2;
    tick();
    iv = 0;
    tick();
    chk("acc_1", longint'(dout0), 12);
    tick();
    chk("acc_2", longint'(dout0), 42);
    tick();
    chk("acc_3", longint'(dout0), 46);
    chk("acc_ov", longint'(ov0), 1);
    tick();
    chk("acc_ov_end", longint'(ov0), 0);
    iv = 1; en = 0; a[0] = 7; b[0] = 9;
    tick();
    iv = 0;
    tick();
    ce = 0;
    repeat (3) begin
      tick();
      chk("ce_low_no_ov", longint'(ov0), 0);
    end
    ce = 1;
    tick();
    tick();
    chk("ce_result", longint'(dout0), 63);
    chk("ce_ov", longint'(ov0), 1);
    ce = 0;
    tick();
    chk("ce_freeze_ov", longint'(ov0), 1);
    ce = 1;
    tick();
    iv = 1; en = 0; a[0] = 9; b[0] = 9;
    repeat (3) tick();
    rst = 1; iv = 0;
    tick();
    rst = 0;
    repeat (4) begin
      tick();
      chk("rst_no_ov", longint'(ov0), 0);
      chk("rst_dout", longint'(dout0), 0);
    end
    iv = 1; en = 1; a[0] = 2; b[0] = 3;
    tick();
    iv = 0;
    repeat (3) tick();
    chk("post_rst", longint'(dout0), 6);
    repeat (600) begin
      rst = $urandom_range(0, 59) == 0;
      ce = $urandom_range(0, 4) != 0;
      iv = $urandom_range(0, 3) != 0;
      en = $urandom_range(0, 2) != 0;
      for (int d = 0; d < 3; d++) begin
        a[d] = 16'($urandom);
        b[d] = 16'($urandom);
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/run_mul_acc_pipe.md
Name: run_mul_acc_pipe

Overview:
- Parametrised pipelined multiplier/multiply-accumulate for the fault-detector datapath.
- Successor to the fixed-width, fixed-latency unsigned DSP multiply.
- Adds per-operand signedness, configurable output width and pipeline depth, a valid pipeline, and an optional running accumulate mode.
- Sits between HLS-generated control and the checker arithmetic. Maps onto DSP48 slices: A/B input registers, M register, P register.

Parameters:
- A_W, 14: width of din0.
- B_W, 15: width of din1.
- A_SIGNED, 0: 1 = din0 is two's complement.
- B_SIGNED, 0: 1 = din1 is two's complement.
- P_W, 29: width of dout and of the accumulator.
- NUM_STAGE, 4: total latency in ce-enabled cycles, din to dout. Legal range 2..6.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- reset, in, 1: synchronous, active-high reset.
- ce, in, 1: clock enable; when low, every register in the block holds, including valid and accumulator.
- din0, in, A_W: multiplicand.
- din1, in, B_W: multiplier.
- in_valid, in, 1: din0/din1/acc_en qualify a sample this cycle.
- acc_en, in, 1: travels with the sample. 1 = add product to accumulator; 0 = load accumulator with product.
- dout, out, P_W: result register (product or accumulated sum).
- out_valid, out, 1: dout holds a new result from a valid sample.

Behaviour:
- Reset: on a clk edge with reset=1 (regardless of ce), clear to 0: all pipeline data registers, the valid shift chain, acc_en tags, accumulator, dout and out_valid. Reset mid-operation discards all in-flight samples; the first valid sample after reset appears NUM_STAGE ce-cycles after it is presented.
- Operand extension:
  - din0 is extended by 1 bit: sign bit if A_SIGNED, else 0. din1 likewise with B_SIGNED.
  - Multiply is signed on (A_W+1)x(B_W+1) bits.
  - Full product width FW = A_W+B_W.
  - Result is signed if A_SIGNED or B_SIGNED.
- Stage layout:
  - Stage 1 registers operands, valid and acc_en.
  - Stages 2..NUM_STAGE-1 carry the product: product formed after stage 1, then registered and delayed.
  - Final stage is the accumulator/output register.
  - With NUM_STAGE=2 the product is combinational between the stage-1 registers and the output register.
- Width conversion of product to P_W:
  - P_W >= FW: sign-extend if result is signed, else zero-extend.
  - P_W < FW: keep low P_W bits.
- Output stage, when ce=1:
  - valid sample, acc_en=0: acc <= prod_p.
  - valid sample, acc_en=1: acc <= acc + prod_p, wrapping modulo 2^P_W.
  - no valid sample: acc holds.
  - dout = acc. out_valid <= final-stage valid.
- out_valid is a one-ce-cycle pulse per sample. Bubbles (in_valid=0) propagate as bubbles.
- Throughput: one sample per ce-enabled cycle; no backpressure.
- ce low: no sample is accepted and the sample at din is ignored. Pipeline contents and out_valid freeze, so out_valid stays high while ce is low if it was high.
- Simultaneous reset and ce: reset wins.
- acc_en=1 on the first sample after reset accumulates onto 0, which is equivalent to a load.

Optional Feature:
- Macro: RUN_MUL_ACC_SATURATE_EN.
- Defined:
  - Width conversion and accumulation saturate instead of wrapping.
  - Signed result: clamp to [-2^(P_W-1), 2^(P_W-1)-1]. Unsigned result: clamp to [0, 2^P_W-1].
  - A sticky output port sat_flag (1 bit) is added. It is set when any clamp occurs and cleared by reset or by a valid acc_en=0 sample that does not itself clamp.
  - Saturation logic sits in the final stage; latency is unchanged.
- Not defined: wrapping behaviour only, and no sat_flag port.

Test Plan:
- Defaults, din0=16383, din1=32767, in_valid=1 for one cycle, acc_en=0 -> exactly 4 cycles later dout=536821761 with a one-cycle out_valid pulse.
- A_SIGNED=1, B_SIGNED=1, A_W=B_W=8, P_W=16, din0=-128, din1=-128 -> dout=16384. Then din0=-1, din1=5 -> dout=0xFFFB (-5).
- Accumulate, defaults: samples (3,4,acc_en=0), (5,6,1), (2,2,1) back-to-back -> dout sequence 12, 42, 46 on consecutive cycles, out_valid high 3 cycles.
- ce toggling: issue sample (7,9), hold ce low 3 cycles mid-flight -> dout=63 after 4 ce-high cycles; no out_valid while ce is low before arrival.
- Reset mid-operation: 3 samples in flight, assert reset 1 cycle -> no out_valid for those samples; dout=0; a new sample (2,3) gives dout=6 after 4 cycles.
- With RUN_MUL_ACC_SATURATE_EN, unsigned P_W=8, A_W=B_W=8: 20x20 -> dout=255, sat_flag=1. Then (2,3,acc_en=0) -> dout=6, sat_flag=0. Without the macro, 20x20 -> dout=144.
